// File: rtl/scomp_io_pkg.sv
// Shared constants and types for SCOMP IO-bus peripherals: bus widths,
// timer register offsets and CTRL/STATUS bit positions.
package scomp_io_pkg;

    localparam int SC_DATA_W = 16;
    localparam int SC_ADDR_W = 8;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int CTRL_EN_BIT          = 0;
    localparam int CTRL_AUTO_RELOAD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT      = 2;
    localparam int CTRL_PRESCALE_LSB    = 8;
    localparam int CTRL_PRESCALE_W      = 8;

    localparam int STATUS_MATCH_BIT = 0;
    localparam int STATUS_OVF_BIT   = 1;

    typedef struct packed {
        logic [CTRL_PRESCALE_W-1:0] prescale;
        logic                       irq_en;
        logic                       auto_reload;
        logic                       en;
    } ctrl_t;

    // Software view of CTRL; the unimplemented bits [7:3] read as zero.
    function automatic logic [SC_DATA_W-1:0] pack_ctrl(input ctrl_t c);
        logic [SC_DATA_W-1:0] v;
        v = '0;
        v[CTRL_EN_BIT]          = c.en;
        v[CTRL_AUTO_RELOAD_BIT] = c.auto_reload;
        v[CTRL_IRQ_EN_BIT]      = c.irq_en;
        v[CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W] = c.prescale;
        return v;
    endfunction

endpackage

// File: rtl/scomp_io_timer_if.sv
// SCOMP IO-bus control signals (cycle, direction, address) as seen by a
// peripheral; the shared data bus stays a separate inout net.
interface scomp_io_timer_if;
    import scomp_io_pkg::*;

    logic                 iocyc;
    logic                 iowr;
    logic [SC_ADDR_W-1:0] ioaddr;

    modport master (output iocyc, iowr, ioaddr);
    modport slave  (input  iocyc, iowr, ioaddr);

endinterface

// File: rtl/scomp_io_timer_slave_if.sv
// Reusable SCOMP IO slave front end: address decode, one-shot write strobe
// per IO cycle, and a read driver that holds its first-cycle value.
module scomp_io_slave_if
    import scomp_io_pkg::*;
#(
    parameter logic [SC_ADDR_W-1:0] BASE_ADDR = 8'h20
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    scomp_io_timer_if.slave      bus,
    inout  wire  [SC_DATA_W-1:0] io_sc_iodata,
    input  logic [SC_DATA_W-1:0] i_rd_data,
    output logic                 o_wr_stb,
    output logic [1:0]           o_offset,
    output logic [SC_DATA_W-1:0] o_wdata
);

    logic                 hit;
    logic                 first;
    logic                 rd_oe;
    logic [SC_DATA_W-1:0] rd_val;

    logic                 iocyc_d, iocyc_q;
    logic                 stale_d, stale_q;
    logic [SC_DATA_W-1:0] rd_hold_d, rd_hold_q;

    always_comb begin
        hit     = (bus.ioaddr[SC_ADDR_W-1:2] == BASE_ADDR[SC_ADDR_W-1:2]);
        first   = bus.iocyc & ~iocyc_q & ~stale_q;
        iocyc_d = bus.iocyc;
        // A cycle that straddled reset stays stale until iocyc drops.
        stale_d = stale_q & bus.iocyc;

        rd_oe     = bus.iocyc & ~bus.iowr & hit & ~i_reset;
        rd_val    = first ? i_rd_data : rd_hold_q;
        rd_hold_d = (first & ~bus.iowr & hit) ? i_rd_data : rd_hold_q;

        o_wr_stb = first & bus.iowr & hit;
        o_offset = bus.ioaddr[1:0];
        o_wdata  = io_sc_iodata;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            iocyc_q   <= 1'b0;
            stale_q   <= bus.iocyc;
            rd_hold_q <= '0;
        end else begin
            iocyc_q   <= iocyc_d;
            stale_q   <= stale_d;
            rd_hold_q <= rd_hold_d;
        end
    end

    assign io_sc_iodata = rd_oe ? rd_val : 'z;

endmodule

// File: rtl/scomp_io_timer.sv
// SCOMP IO timer: 16-bit prescaled up-counter with compare match, optional
// auto-reload and sticky MATCH/OVF flags. o_irq exists only with SCOMP_TIMER_IRQ_EN.
module scomp_io_timer
    import scomp_io_pkg::*;
#(
    parameter logic [SC_ADDR_W-1:0] BASE_ADDR     = 8'h20,
    parameter logic [SC_DATA_W-1:0] RESET_COMPARE = 16'hFFFF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_sc_iocyc,
    input  logic                 i_sc_iowr,
    input  logic [SC_ADDR_W-1:0] i_sc_ioaddr,
    inout  wire  [SC_DATA_W-1:0] io_sc_iodata
`ifdef SCOMP_TIMER_IRQ_EN
    ,
    output logic                 o_irq
`endif
);

    scomp_io_timer_if bus ();

    assign bus.iocyc  = i_sc_iocyc;
    assign bus.iowr   = i_sc_iowr;
    assign bus.ioaddr = i_sc_ioaddr;

    logic                 wr_stb;
    logic [1:0]           offset;
    logic [SC_DATA_W-1:0] wdata;
    logic [SC_DATA_W-1:0] rd_data;

    scomp_io_slave_if #(.BASE_ADDR(BASE_ADDR)) u_slave (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .bus          (bus),
        .io_sc_iodata (io_sc_iodata),
        .i_rd_data    (rd_data),
        .o_wr_stb     (wr_stb),
        .o_offset     (offset),
        .o_wdata      (wdata)
    );

    ctrl_t                      ctrl_d, ctrl_q;
    logic [SC_DATA_W-1:0]       count_d, count_q;
    logic [SC_DATA_W-1:0]       compare_d, compare_q;
    logic                       match_d, match_q;
    logic                       ovf_d, ovf_q;
    logic [CTRL_PRESCALE_W-1:0] pre_cnt_d, pre_cnt_q;

    logic wr_ctrl, wr_count, wr_compare, wr_status;
    logic tick, at_compare, reload;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        match_d   = match_q;
        ovf_d     = ovf_q;
        pre_cnt_d = '0;
        tick      = 1'b0;

        wr_ctrl    = wr_stb & (offset == REG_CTRL);
        wr_count   = wr_stb & (offset == REG_COUNT);
        wr_compare = wr_stb & (offset == REG_COMPARE);
        wr_status  = wr_stb & (offset == REG_STATUS);

        if (ctrl_q.en) begin
            if (pre_cnt_q == ctrl_q.prescale) tick = 1'b1;
            else                              pre_cnt_d = pre_cnt_q + 1'b1;
        end
        // Disabling via CTRL is immediate: no tick on the disabling edge.
        if (wr_ctrl && !wdata[CTRL_EN_BIT]) begin
            tick      = 1'b0;
            pre_cnt_d = '0;
        end

        at_compare = (count_q == compare_q);
        reload     = at_compare & ctrl_q.auto_reload;
        if (tick) count_d = reload ? '0 : count_q + 1'b1;

        // W1C first, then hardware sets, so a coincident set survives.
        if (wr_status) begin
            match_d = match_q & ~wdata[STATUS_MATCH_BIT];
            ovf_d   = ovf_q   & ~wdata[STATUS_OVF_BIT];
        end
        if (tick && at_compare)                      match_d = 1'b1;
        if (tick && (&count_q) && !reload)           ovf_d   = 1'b1;

        if (wr_ctrl) begin
            ctrl_d.en          = wdata[CTRL_EN_BIT];
            ctrl_d.auto_reload = wdata[CTRL_AUTO_RELOAD_BIT];
`ifdef SCOMP_TIMER_IRQ_EN
            ctrl_d.irq_en      = wdata[CTRL_IRQ_EN_BIT];
`endif
            ctrl_d.prescale    = wdata[CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W];
        end
        if (wr_count) begin
            count_d   = wdata;
            pre_cnt_d = '0;
        end
        if (wr_compare) compare_d = wdata;

        rd_data = '0;
        case (offset)
            REG_CTRL:    rd_data = pack_ctrl(ctrl_q);
            REG_COUNT:   rd_data = count_q;
            REG_COMPARE: rd_data = compare_q;
            default: begin
                rd_data[STATUS_MATCH_BIT] = match_q;
                rd_data[STATUS_OVF_BIT]   = ovf_q;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= RESET_COMPARE;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
            pre_cnt_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
            pre_cnt_q <= pre_cnt_d;
        end
    end

`ifdef SCOMP_TIMER_IRQ_EN
    assign o_irq = ctrl_q.irq_en & (match_q | ovf_q) & ~i_reset;
`endif

endmodule

// File: tb/tb_scomp_io_timer.sv
// Scoreboarded bench for scomp_io_timer: directed scenarios plus random IO
// traffic, checked against a behavioural register-level timer model.
module tb_scomp_io_timer;
    import scomp_io_pkg::*;

    localparam logic [7:0] BASE = 8'h20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scomp_io_timer_if bus_if ();

    wire  [15:0] iodata;
    logic        tb_drv;
    logic [15:0] tb_data;
    assign iodata = tb_drv ? tb_data : 16'hzzzz;

`ifdef SCOMP_TIMER_IRQ_EN
    logic irq;
`endif

    scomp_io_timer #(.BASE_ADDR(BASE), .RESET_COMPARE(16'hFFFF)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_sc_iocyc   (bus_if.iocyc),
        .i_sc_iowr    (bus_if.iowr),
        .i_sc_ioaddr  (bus_if.ioaddr),
        .io_sc_iodata (iodata)
`ifdef SCOMP_TIMER_IRQ_EN
        ,
        .o_irq        (irq)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_released(input string name);
        total++;
        if (!(iodata === 16'h0000 || iodata === 16'hzzzz)) begin
            bad++;
            $display("FAIL %s: bus shows %h, expected released", name, iodata);
        end
    endtask

    function automatic bit hit(input logic [7:0] a);
        return a[7:2] == BASE[7:2];
    endfunction

    // Behavioural model: register contents and elapsed prescale clocks.
    logic        m_en, m_ar, m_ie, m_match, m_ovf, m_prev_cyc;
    logic [7:0]  m_ps, m_pre;
    logic [15:0] m_count, m_cmp;

    function automatic logic [15:0] model_read(input logic [1:0] off);
        case (off)
            2'd0:    return {m_ps, 5'b0, m_ie, m_ar, m_en};
            2'd1:    return m_count;
            2'd2:    return m_cmp;
            default: return {14'b0, m_ovf, m_match};
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit          wr, tick;
        logic [1:0]  off;
        logic [15:0] wd;
        int          nc, np;
        bit          set_m, set_o;
        if (rst) begin
            m_en = 0; m_ar = 0; m_ie = 0; m_ps = 0; m_pre = 0;
            m_count = 0; m_cmp = 16'hFFFF; m_match = 0; m_ovf = 0;
        end else begin
            wr   = bus_if.iocyc && !m_prev_cyc && bus_if.iowr && hit(bus_if.ioaddr);
            off  = bus_if.ioaddr[1:0];
            wd   = tb_data;
            tick = m_en && (m_pre == m_ps);
            np   = (m_en && !tick) ? int'(m_pre) + 1 : 0;
            if (wr && off == 2'd0 && !wd[0]) begin tick = 0; np = 0; end
            nc = m_count; set_m = 0; set_o = 0;
            if (tick) begin
                if (m_count == m_cmp && m_ar) begin
                    nc = 0; set_m = 1;
                end else begin
                    nc = (int'(m_count) + 1) % 65536;
                    set_m = (m_count == m_cmp);
                    set_o = (m_count == 16'hFFFF);
                end
            end
            if (wr && off == 2'd3) begin
                if (wd[0]) m_match = 0;
                if (wd[1]) m_ovf = 0;
            end
            if (set_m) m_match = 1;
            if (set_o) m_ovf = 1;
            if (wr && off == 2'd0) begin
                m_en = wd[0]; m_ar = wd[1]; m_ps = wd[15:8];
`ifdef SCOMP_TIMER_IRQ_EN
                m_ie = wd[2];
`endif
            end
            if (wr && off == 2'd1) begin nc = wd; np = 0; end
            if (wr && off == 2'd2) m_cmp = wd;
            m_count = nc[15:0];
            m_pre   = np[7:0];
        end
        m_prev_cyc = bus_if.iocyc;
    end

    // Scoreboard: expected read data queued at issue, compared by the monitor.
    logic [15:0] exp_q[$];
    logic [15:0] cur_exp;
    bit          mon_active = 0;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 0;
        end else begin
            if (bus_if.iocyc && !bus_if.iowr && hit(bus_if.ioaddr)) begin
                if (!mon_active) begin
                    mon_active = 1;
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL read_unexpected: got %h, no expected value queued", iodata);
                    end else begin
                        cur_exp = exp_q.pop_front();
                    end
                end
                check("read", iodata, cur_exp);
            end else begin
                mon_active = 0;
            end
`ifdef SCOMP_TIMER_IRQ_EN
            check("o_irq", {15'b0, irq}, {15'b0, m_ie & (m_match | m_ovf)});
`endif
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [15:0] d,
                            input int hold, input logic [15:0] d_later);
        bus_if.iocyc = 1; bus_if.iowr = 1; bus_if.ioaddr = a;
        tb_drv = 1; tb_data = d;
        wait_clks(1);
        tb_data = d_later;
        if (hold > 1) wait_clks(hold - 1);
        bus_if.iocyc = 0; bus_if.iowr = 0; tb_drv = 0;
        wait_clks(1);
    endtask

    task automatic wr(input logic [1:0] off, input logic [15:0] d);
        io_write(BASE | 8'(off), d, 1, d);
    endtask

    task automatic io_read(input logic [7:0] a, input int hold,
                           input bit use_exp, input logic [15:0] exp);
        if (hit(a)) exp_q.push_back(use_exp ? exp : model_read(a[1:0]));
        bus_if.iocyc = 1; bus_if.iowr = 0; bus_if.ioaddr = a;
        wait_clks(hold);
        bus_if.iocyc = 0;
        wait_clks(1);
    endtask

    task automatic rd_exp(input logic [1:0] off, input logic [15:0] exp);
        io_read(BASE | 8'(off), 1, 1, exp);
    endtask

    task automatic rd_model(input logic [1:0] off, input int hold);
        io_read(BASE | 8'(off), hold, 0, 16'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        rst = 1; tb_drv = 0; tb_data = 0;
        bus_if.iocyc = 0; bus_if.iowr = 0; bus_if.ioaddr = 0;
        wait_clks(3);
        rst = 0;
        wait_clks(1);

        // Reset values and idle bus.
        rd_exp(REG_CTRL, 16'h0000);
        rd_exp(REG_COUNT, 16'h0000);
        rd_exp(REG_COMPARE, 16'hFFFF);
        rd_exp(REG_STATUS, 16'h0000);
        @(negedge clk);
        check_released("idle_release");
`ifdef SCOMP_TIMER_IRQ_EN
        check("irq_after_reset", {15'b0, irq}, 16'h0);
`endif
        @(posedge clk); #1;

        // Auto-reload at COMPARE=5, prescale 0.
        wr(REG_COMPARE, 16'd5);
        wr(REG_COUNT, 16'd0);
        wr(REG_CTRL, 16'h0003);
        wait_clks(20);
        rd_exp(REG_STATUS, 16'h0001);
        rd_model(REG_COUNT, 1);
        rd_model(REG_COUNT, 5);
        wr(REG_CTRL, 16'h0000);
        wr(REG_STATUS, 16'h0003);
        rd_exp(REG_STATUS, 16'h0000);

        // Prescale 3: one count per 4 clocks.
        wr(REG_COMPARE, 16'hFFFF);
        wr(REG_CTRL, 16'h0301);
        wr(REG_COUNT, 16'h0000);
        wait_clks(39);
        rd_exp(REG_COUNT, 16'd10);
        wr(REG_CTRL, 16'h0000);

        // Overflow from FFFF and W1C of OVF.
        wr(REG_STATUS, 16'h0003);
        wr(REG_COUNT, 16'hFFFF);
        wr(REG_COMPARE, 16'h1234);
        wr(REG_CTRL, 16'h0001);
        rd_exp(REG_STATUS, 16'h0002);
        rd_model(REG_COUNT, 1);
        wr(REG_STATUS, 16'h0002);
        rd_exp(REG_STATUS, 16'h0000);
        wr(REG_CTRL, 16'h0000);

        // W1C on the same edge as a new MATCH: flag must stay set.
        wr(REG_COUNT, 16'h0040);
        wr(REG_COMPARE, 16'h0040);
        wr(REG_CTRL, 16'h0001);
        wr(REG_CTRL, 16'h0000);
        rd_exp(REG_STATUS, 16'h0001);
        wr(REG_COUNT, 16'h0040);
        wr(REG_CTRL, 16'h0201);
        wait_clks(1);
        wr(REG_STATUS, 16'h0001);
        rd_exp(REG_STATUS, 16'h0001);
        wr(REG_CTRL, 16'h0000);
        wr(REG_STATUS, 16'h0001);
        rd_exp(REG_STATUS, 16'h0000);

        // Held write takes only the first-cycle data; foreign address ignored.
        io_write(BASE | 8'd2, 16'h1111, 5, 16'h2222);
        rd_exp(REG_COMPARE, 16'h1111);
        io_write(8'h24, 16'hBEEF, 1, 16'hBEEF);
        rd_exp(REG_COMPARE, 16'h1111);
        bus_if.iocyc = 1; bus_if.iowr = 0; bus_if.ioaddr = 8'h24;
        @(negedge clk);
        check_released("foreign_read_release");
        @(posedge clk); #1;
        bus_if.iocyc = 0;
        wait_clks(1);

`ifdef SCOMP_TIMER_IRQ_EN
        // Interrupt on match.
        wr(REG_COMPARE, 16'd3);
        wr(REG_COUNT, 16'd0);
        wr(REG_CTRL, 16'h0007);
        wait_clks(8);
        check("irq_on_match", {15'b0, irq}, 16'h1);
        wr(REG_CTRL, 16'h0004);
`endif

        // Reset in the middle of a read, then a cycle straddling reset release.
        wr(REG_COMPARE, 16'hA5A5);
        exp_q.push_back(model_read(REG_COMPARE));
        bus_if.iocyc = 1; bus_if.iowr = 0; bus_if.ioaddr = BASE | 8'd2;
        wait_clks(1);
        rst = 1;
        @(negedge clk);
        check_released("reset_mid_read_release");
`ifdef SCOMP_TIMER_IRQ_EN
        check("irq_in_reset", {15'b0, irq}, 16'h0);
`endif
        @(posedge clk); #1;
        bus_if.iowr = 1; tb_drv = 1; tb_data = 16'h7777;
        wait_clks(1);
        rst = 0;
        wait_clks(2);
        bus_if.iocyc = 0; bus_if.iowr = 0; tb_drv = 0;
        wait_clks(1);
        rd_exp(REG_COMPARE, 16'hFFFF);
        rd_exp(REG_CTRL, 16'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 7))
                0: wr(REG_CTRL, {8'($urandom_range(0, 3)), 5'b0,
                                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0)});
                1: begin
                    case ($urandom_range(0, 2))
                        0:       wr(REG_COUNT, m_cmp - 16'($urandom_range(0, 4)));
                        1:       wr(REG_COUNT, 16'hFFFF - 16'($urandom_range(0, 4)));
                        default: wr(REG_COUNT, 16'($urandom));
                    endcase
                end
                2: wr(REG_COMPARE, 16'($urandom_range(0, 12)));
                3: wr(REG_STATUS, 16'($urandom_range(0, 3)));
                4, 5: rd_model(2'($urandom_range(0, 3)), $urandom_range(1, 4));
                6: wait_clks($urandom_range(0, 6));
                default: begin
                    a = 8'($urandom);
                    if (hit(a)) a = a ^ 8'h80;
                    if ($urandom_range(0, 1) == 1)
                        io_write(a, 16'($urandom), $urandom_range(1, 3), 16'($urandom));
                    else
                        io_read(a, $urandom_range(1, 3), 0, 16'h0);
                end
            endcase
        end
        for (int r = 0; r < 4; r++) rd_model(2'(r), 1);

        wait_clks(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d reads expected but never seen", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scomp_io_timer.md
Name: scomp_io_timer

Overview:
SCOMP IO-bus peripheral that sits directly downstream of the Wishbone-to-SCOMP translator. It consumes that translator's iocyc/iowr/ioaddr/iodata bus. It provides a 16-bit prescaled up-counter with compare match, optional auto-reload, sticky status flags and an interrupt. It gives TL45 software a timer reachable through the SCOMP IO window.

Parameters:
BASE_ADDR, 8'h20, IO base address of the 4-register block; must be 4-aligned (bits [1:0] = 0).
RESET_COMPARE, 16'hFFFF, reset value of the COMPARE register.

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous active-high reset
i_sc_iocyc  input  1  SCOMP IO cycle active
i_sc_iowr  input  1  1 = write cycle, 0 = read cycle
i_sc_ioaddr  input  8  IO address; master holds it stable while iocyc is high
io_sc_iodata  inout  16  shared IO data bus; driven only during a read hit, otherwise high-Z
o_irq  output  1  interrupt request; present only with SCOMP_TIMER_IRQ_EN

Behaviour:
- One clock (i_clk). Reset is synchronous and active-high (i_reset).
- Address decode:
  - hit = i_sc_ioaddr[7:2] == BASE_ADDR[7:2].
  - Register offset = i_sc_ioaddr[1:0].
- Register map:
  - 0 CTRL (R/W, reset 0): bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, [15:8] PRESCALE. Bits [7:3] read 0.
  - 1 COUNT (R/W, reset 0).
  - 2 COMPARE (R/W, reset RESET_COMPARE).
  - 3 STATUS (reset 0): bit0 MATCH, bit1 OVF. Both sticky, write-1-to-clear. Other bits read 0.
- Cycle detection:
  - iocyc_q is iocyc registered (reset 0).
  - first = i_sc_iocyc & ~iocyc_q.
- Write:
  - Performed exactly once per IO cycle: on the clock edge where first & i_sc_iowr & hit.
  - io_sc_iodata is sampled at that edge.
  - Further cycles with iocyc held high are ignored.
- Read:
  - Drive enable = i_sc_iocyc & ~i_sc_iowr & hit & ~i_reset.
  - In the first cycle, the bus shows the combinational register mux.
  - That value is captured into rd_hold at the same edge and driven for the rest of the cycle, so read data is stable.
  - Reads have no side effects.
- Prescaler:
  - 8-bit pre_cnt, held at 0 while EN=0.
  - While EN=1, pre_cnt increments each clock.
  - When pre_cnt == PRESCALE: pre_cnt <= 0 and tick = 1. Tick rate is clk/(PRESCALE+1); PRESCALE=0 gives a tick every clock.
- Counting on tick:
  - If count == COMPARE: MATCH <= 1, and count <= AUTO_RELOAD ? 0 : count+1.
  - Otherwise count <= count+1, wrapping modulo 2^16.
  - If count == 16'hFFFF and the next value comes from the increment (not a reload): OVF <= 1.
  - Reload from FFFF to 0 with COMPARE=FFFF sets MATCH only.
- Simultaneous events:
  - Software write to COUNT on a tick edge: the write wins, and pre_cnt is cleared to 0.
  - Write to CTRL clearing EN: takes effect that edge; no tick on that edge.
  - STATUS W1C on the same edge as a hardware set of the same flag: the set wins (flag stays 1).
- o_irq:
  - o_irq = IRQ_EN & (MATCH | OVF), driven from registered bits.
  - Reset value 0.
- Reset, including mid IO cycle:
  - All registers and iocyc_q return to reset values.
  - Bus released to high-Z that cycle.
  - A cycle still in progress after reset deasserts is not a "first" cycle, so no write occurs.

Optional Feature:
SCOMP_TIMER_IRQ_EN
- Defined: o_irq port exists; CTRL.IRQ_EN is implemented with reset 0.
- Undefined: o_irq port is absent; CTRL bit2 reads 0 and ignores writes; software polls STATUS.

Decomposition:
- Package scomp_io_pkg holds:
  - SC_DATA_W = 16 and SC_ADDR_W = 8.
  - Register offset constants REG_CTRL/REG_COUNT/REG_COMPARE/REG_STATUS.
  - CTRL and STATUS bit-position constants.
- Sub-module scomp_io_slave_if (reusable by later SCOMP peripherals) owns:
  - address decode;
  - iocyc_q and first detection;
  - write strobe, offset and write data outputs;
  - rd_hold capture and tri-state driver.
- The timer core (prescaler, counter, flags) stays in scomp_io_timer.

Test Plan:
- Reset, then read BASE+0..3 -> 0x0000, 0x0000, 0xFFFF, 0x0000; bus high-Z when idle; o_irq = 0.
- Write COMPARE=5, CTRL=0x0003 (EN, AUTO_RELOAD, PRESCALE=0) -> COUNT runs 0..5,0..; MATCH set on the edge where count==5 ticks; count returns to 0; OVF stays 0.
- CTRL=0x0301 (PRESCALE=3), COUNT=0 -> COUNT increments once every 4 clocks; after 40 clocks reads 10.
- COUNT=0xFFFF, COMPARE=0x1234, EN=1 -> next tick: COUNT=0, OVF=1. Write STATUS=0x0002 -> OVF=0. A W1C coinciding with a new set leaves the flag at 1.
- IO write held 5 cycles with data changing after cycle 1 -> register takes the first-cycle value only. Read held 5 cycles while COUNT ticks -> bus shows the constant first-cycle value.
- SCOMP_TIMER_IRQ_EN defined, IRQ_EN=1, match occurs -> o_irq rises the cycle after MATCH sets. i_reset asserted mid read -> bus high-Z and o_irq=0 the same cycle.
